datagate_mc: RTL
================

Name: datagate_mc

Overview:
- Multi-channel, parametrised data gate for low-power datapaths.
- Each channel forces its output bus to a quiet value when it has seen no valid data for a programmable number of cycles. This stops toggling from propagating into downstream logic.
- Next generation of the single-channel fixed-depth gate:
  - run-time programmable quiet time (down-counter instead of a shift pipe)
  - per-channel operation
  - selectable quiet value: zero or hold-last
  - global bypass
  - registered idle status for the power controller

Parameters:
- DW, 32, data width per channel
- N, 4, number of independent channels (N >= 1)
- CW, 4, quiet-time counter width; maximum quiet time 2^CW-1 cycles

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- en  input  N  per-channel data valid; bit i qualifies din channel i
- din  input  N*DW  channel data, channel i at bits [i*DW +: DW]
- cfg_hold  input  CW  quiet time in cycles after last en before the gate closes; shared by all channels
- cfg_mode  input  1  quiet value select: 0 = drive zero, 1 = hold last passed value
- bypass  input  1  1 = all gates forced open (test/debug)
- dout  output  N*DW  gated data, same packing as din
- open  output  N  per-channel gate-open indication (combinational)
- idle  output  1  registered; 1 when every channel has been closed for a full cycle

Behaviour:
- Interface fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- Per channel i, state is cnt_i (CW bits) and last_i (DW bits). All state, including idle, is updated only on posedge clk or async reset.
- Reset (async, active-high):
  - cnt_i = 0, last_i = 0, idle = 1.
  - dout/open remain combinational from en/bypass, so en=1 during reset still passes din.
- Counter rules, evaluated each cycle in priority order:
  - en[i]=1: cnt_i <= cfg_hold, sampled that cycle.
  - else cnt_i != 0: cnt_i <= cnt_i - 1.
  - else cnt_i holds 0.
  - No wrap-around: cnt_i never decrements below 0.
- Gate: open[i] = bypass | en[i] | (cnt_i != 0).
  - Channel stays open exactly cfg_hold cycles after the last cycle with en[i]=1.
  - cfg_hold = 0 gives pure same-cycle en gating.
  - A fixed depth of PS matches a cfg_hold value of PS.
- Data, combinational, zero latency:
  - open[i]=1: dout_i = din_i.
  - open[i]=0 and cfg_mode=0: dout_i = 0.
  - open[i]=0 and cfg_mode=1: dout_i = last_i.
- last_i capture:
  - last_i <= din_i on every cycle where en[i]=1.
  - Data passed only because of bypass or a nonzero counter, without en, is not captured; hold mode replays the last qualified word.
- cfg_hold changes:
  - A change mid-countdown does not affect a running cnt_i.
  - The new value applies at the next en load.
- en re-asserted while counting: reload to cfg_hold (retrigger). There is no accumulation.
- cfg_mode changes take effect combinationally on closed channels.
- bypass:
  - Does not alter cnt_i.
  - On deassertion, each channel reverts to its counter/en state that same cycle.
- idle <= ~|open, registered.
  - idle is 1 the cycle after all channels are closed.
  - idle drops one cycle after any en or bypass.
- Channels are fully independent. Simultaneous en on multiple channels has no interaction.
- Reset mid-countdown immediately closes channels with en=0 and bypass=0. In hold mode, dout then shows 0 (last cleared).

Test Plan:
- Reset with en=0, bypass=0, cfg_mode=0, din=all 0xA5A5A5A5 -> dout=0, open=0, idle=1.
- cfg_hold=3, cfg_mode=0, en[0] pulse 1 cycle (t0) with din0=0x12345678 held:
  - dout0=0x12345678 at t0..t0+3
  - dout0=0 from t0+4
  - open[0] low at t0+4, idle high at t0+5
  - other channels stay 0.
- cfg_mode=1, en[1] with din1=0xDEADBEEF at t0, then din1=0x11111111 with en low, cfg_hold=2:
  - t0+1..t0+2 dout1=0x11111111 (open, passes din)
  - from t0+3 dout1=0xDEADBEEF.
- Retrigger: cfg_hold=4, en[2] at t0 and t0+3 -> open[2] continuously t0..t0+7, closed at t0+8.
- cfg_hold=0, en[3] toggling 1,0,1,0 -> dout3 follows en exactly, no extra cycles; cnt never nonzero.
- bypass=1 for 3 cycles with en=0:
  - all dout=din, idle drops one cycle later
  - after bypass=0, dout returns to quiet value the same cycle
  - reset asserted mid-countdown of a cfg_hold=7 channel closes it asynchronously.

Source files
------------

// File: rtl/datagate_mc.sv
// Multi-channel data gate: each channel drives a quiet value once it has seen
// no valid data for a run-time programmable number of cycles.
module datagate_mc #(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    en,
  input  logic [N*DW-1:0] din,
  input  logic [CW-1:0]   cfg_hold,
  input  logic            cfg_mode,
  input  logic            bypass,
  output logic [N*DW-1:0] dout,
  output logic [N-1:0]    open,
  output logic            idle
);

  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0][DW-1:0] last_q, last_d;
  logic                 idle_q, idle_d;
  logic [N-1:0]         open_c;
  logic [N*DW-1:0]      dout_c;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    open_c = '0;
    dout_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      open_c[i] = bypass | en[i] | (cnt_q[i] != '0);
      // Bypass never touches the counter; only qualified data is remembered.
      if (en[i]) begin
        cnt_d[i]  = cfg_hold;
        last_d[i] = din[i*DW +: DW];
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (open_c[i]) begin
        dout_c[i*DW +: DW] = din[i*DW +: DW];
      end else if (cfg_mode) begin
        dout_c[i*DW +: DW] = last_q[i];
      end
    end
    idle_d = ~|open_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= '0;
      idle_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      idle_q <= idle_d;
    end
  end

  assign open = open_c;
  assign dout = dout_c;
  assign idle = idle_q;

endmodule
